// File: rtl/autocorr_pkg.sv
// Shared types and width helpers for the streaming multi-lag autocorrelator.
package autocorr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  // Accumulator width: a full signed product plus log2(N) bits of growth.
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int lag_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/autocorr_engine_lag_mac.sv
// One lag's signed multiply-accumulate with synchronous clear and enable.
module lag_mac #(
  parameter int DW    = 16,
  parameter int ACC_W = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = a * b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/autocorr_engine.sv
// Streaming autocorrelator: accumulates r[k] over an N-sample frame for
// k = 0..M-1, then drains one lag per beat over a valid/ready port.
module autocorr_engine
  import autocorr_pkg::*;
#(
  parameter int DW   = 16,
  parameter int N    = 64,
  parameter int M    = 8,
  parameter int NORM = 1,
  localparam int ACC_W = acc_w(DW, N),
  localparam int LW    = lag_w(M)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [LW-1:0]           out_lag,
  output logic                    out_last,
  output logic                    busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SH = $clog2(N);
  localparam int DL = (M > 1) ? M - 1 : 1;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt;
  logic [LW-1:0]           idx;
  logic signed [DW-1:0]    dly [DL];
  logic signed [ACC_W-1:0] acc [M];
  logic signed [ACC_W-1:0] sel, scaled;
  logic                    accept, frame_end, beat, last_beat, clear;

  assign accept    = in_valid && (state == ACCUM);
  assign frame_end = accept && (cnt == CW'(N - 1));
  assign beat      = (state == DRAIN) && out_ready;
  assign last_beat = beat && (idx == LW'(M - 1));
  assign clear     = (state == IDLE) || last_beat;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ACCUM;
      ACCUM:   if (frame_end) state_nx = DRAIN;
      DRAIN:   if (last_beat) state_nx = ACCUM;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (frame_end)   cnt <= '0;
      else if (accept) cnt <= cnt + CW'(1);
      if (last_beat)   idx <= '0;
      else if (beat)   idx <= idx + LW'(1);
    end
  end

  // NOTE: the delay line is a storage array that does need clearing: the
  // zeroed taps are what make terms with n < k contribute nothing.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DL; i++) dly[i] <= '0;
    end else if (accept) begin
      dly[0] <= in_data;
      for (int i = 1; i < DL; i++) dly[i] <= dly[i-1];
    end
  end

  for (genvar k = 0; k < M; k++) begin : g_lag
    logic signed [DW-1:0] tap;
    if (k == 0) begin : g_sq
      assign tap = in_data;
    end else begin : g_dly
      assign tap = dly[k-1];
    end
    lag_mac #(
      .DW   (DW),
      .ACC_W(ACC_W)
    ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .en   (accept),
      .a    (in_data),
      .b    (tap),
      .acc  (acc[k])
    );
  end

  // Biased normalisation floors toward minus infinity via arithmetic shift.
  assign sel    = acc[idx];
  assign scaled = (NORM != 0) ? (sel >>> SH) : sel;

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? scaled : '0;
  assign out_lag   = idx;
  assign out_last  = out_valid && (idx == LW'(M - 1));

endmodule

// File: tb/tb_autocorr_engine.sv
// Directed bench for autocorr_engine (DW=8, N=4, M=2); raw and normalised
// instances run side by side on the same stimulus.
module tb_autocorr_engine;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int M  = 2;
  localparam int AW = 2 * DW + 2;
  localparam int LW = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] in_data = '0;

  logic                 in_ready0, out_valid0, out_last0, busy0;
  logic                 in_ready1, out_valid1, out_last1, busy1;
  logic signed [AW-1:0] out_data0, out_data1;
  logic [LW-1:0]        out_lag0, out_lag1;

  int vectors = 0;
  int miscompares = 0;

  logic signed [AW-1:0] cap0 [M];
  logic signed [AW-1:0] cap1 [M];
  logic [LW-1:0]        cap_lag [M];
  logic                 cap_last [M];

  always #5 clk = ~clk;

  autocorr_engine #(.DW(DW), .N(N), .M(M), .NORM(0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_lag(out_lag0), .out_last(out_last0),
    .busy(busy0)
  );

  autocorr_engine #(.DW(DW), .N(N), .M(M), .NORM(1)) u_norm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_lag(out_lag1), .out_last(out_last1),
    .busy(busy1)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sample(input logic signed [DW-1:0] s);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = s;
    while (!in_ready0 && waited < 20) begin
      step();
      waited++;
    end
    vectors++;
    if (in_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL in_ready_wait: got %0b expected 1", in_ready0);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int s0, input int s1, input int s2, input int s3,
                            input bit gap = 1'b0);
    int s [4];
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      send_sample(DW'(s[i]));
      if (gap && i < 3) step();
    end
  endtask

  task automatic collect_drain();
    int waited;
    out_ready = 1'b1;
    for (int b = 0; b < M; b++) begin
      waited = 0;
      while (!out_valid0 && waited < 20) begin
        step();
        waited++;
      end
      vectors++;
      if (out_valid0 !== 1'b1) begin
        miscompares++;
        $display("FAIL drain_beat%0d_wait: out_valid got %0b expected 1", b, out_valid0);
      end
      cap0[b]     = out_data0;
      cap1[b]     = out_data1;
      cap_lag[b]  = out_lag0;
      cap_last[b] = out_last0;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(2);
    vectors += 2;
    if ({in_ready0, out_valid0, out_data0, out_lag0, out_last0, busy0} !== '0) begin
      miscompares++;
      $display("FAIL reset_raw: outputs got %h expected 0",
               {in_ready0, out_valid0, out_data0, out_lag0, out_last0, busy0});
    end
    if ({in_ready1, out_valid1, out_data1, out_lag1, out_last1, busy1} !== '0) begin
      miscompares++;
      $display("FAIL reset_norm: outputs got %h expected 0",
               {in_ready1, out_valid1, out_data1, out_lag1, out_last1, busy1});
    end
    rst = 1'b0;
    vectors += 2;
    if (in_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL first_cycle_in_ready: got %0b expected 0", in_ready0);
    end
    if (busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL first_cycle_busy: got %0b expected 0", busy0);
    end
    step();
    vectors += 2;
    if (in_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL second_cycle_in_ready: got %0b expected 1", in_ready0);
    end
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL second_cycle_busy: got %0b expected 1", busy0);
    end
  endtask

  task automatic test_constant();
    int raw [M];
    int nrm [M];
    raw = '{16, 12};
    nrm = '{4, 3};
    send_frame(2, 2, 2, 2);
    vectors += 2;
    if (out_valid0 !== 1'b1) begin
      miscompares++;
      $display("FAIL const_latency: out_valid got %0b expected 1", out_valid0);
    end
    if (in_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL const_drain_in_ready: got %0b expected 0", in_ready0);
    end
    collect_drain();
    for (int b = 0; b < M; b++) begin
      vectors += 4;
      if (cap0[b] !== AW'(raw[b])) begin
        miscompares++;
        $display("FAIL const_raw_lag%0d: got %0d expected %0d", b, cap0[b], raw[b]);
      end
      if (cap1[b] !== AW'(nrm[b])) begin
        miscompares++;
        $display("FAIL const_norm_lag%0d: got %0d expected %0d", b, cap1[b], nrm[b]);
      end
      if (cap_lag[b] !== LW'(b)) begin
        miscompares++;
        $display("FAIL const_out_lag%0d: got %0d expected %0d", b, cap_lag[b], b);
      end
      if (cap_last[b] !== (b == M - 1)) begin
        miscompares++;
        $display("FAIL const_out_last%0d: got %0b expected %0b", b, cap_last[b], b == M - 1);
      end
    end
    vectors++;
    if (in_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL const_post_drain_in_ready: got %0b expected 1", in_ready0);
    end
  endtask

  task automatic test_back_to_back_ramp();
    int raw [M];
    int nrm [M];
    raw = '{30, 20};
    nrm = '{7, 5};
    for (int f = 0; f < 2; f++) begin
      send_frame(1, 2, 3, 4);
      collect_drain();
      for (int b = 0; b < M; b++) begin
        vectors += 3;
        if (cap0[b] !== AW'(raw[b])) begin
          miscompares++;
          $display("FAIL ramp_f%0d_raw_lag%0d: got %0d expected %0d", f, b, cap0[b], raw[b]);
        end
        if (cap1[b] !== AW'(nrm[b])) begin
          miscompares++;
          $display("FAIL ramp_f%0d_norm_lag%0d: got %0d expected %0d", f, b, cap1[b], nrm[b]);
        end
        if (cap_last[b] !== (b == M - 1)) begin
          miscompares++;
          $display("FAIL ramp_f%0d_last%0d: got %0b expected %0b", f, b, cap_last[b], b == M - 1);
        end
      end
    end
  endtask

  task automatic test_alternating();
    int raw [M];
    int nrm [M];
    raw = '{36, -27};
    nrm = '{9, -7};
    send_frame(-3, 3, -3, 3);
    collect_drain();
    for (int b = 0; b < M; b++) begin
      vectors += 2;
      if (cap0[b] !== AW'(raw[b])) begin
        miscompares++;
        $display("FAIL alt_raw_lag%0d: got %0d expected %0d", b, cap0[b], raw[b]);
      end
      if (cap1[b] !== AW'(nrm[b])) begin
        miscompares++;
        $display("FAIL alt_norm_lag%0d: got %0d expected %0d", b, cap1[b], nrm[b]);
      end
    end
  endtask

  task automatic test_stall();
    int raw [M];
    int nrm [M];
    raw = '{30, 20};
    nrm = '{7, 5};
    send_frame(1, 2, 3, 4);
    in_valid = 1'b1;
    in_data  = 8'sd9;
    for (int c = 0; c < 5; c++) begin
      vectors += 5;
      if (out_valid0 !== 1'b1) begin
        miscompares++;
        $display("FAIL stall%0d_valid: got %0b expected 1", c, out_valid0);
      end
      if (out_lag0 !== LW'(0)) begin
        miscompares++;
        $display("FAIL stall%0d_lag: got %0d expected 0", c, out_lag0);
      end
      if (out_data0 !== AW'(30)) begin
        miscompares++;
        $display("FAIL stall%0d_raw: got %0d expected 30", c, out_data0);
      end
      if (out_data1 !== AW'(7)) begin
        miscompares++;
        $display("FAIL stall%0d_norm: got %0d expected 7", c, out_data1);
      end
      if (in_ready0 !== 1'b0) begin
        miscompares++;
        $display("FAIL stall%0d_in_ready: got %0b expected 0", c, in_ready0);
      end
      step();
    end
    in_valid = 1'b0;
    collect_drain();
    for (int b = 0; b < M; b++) begin
      vectors += 3;
      if (cap0[b] !== AW'(raw[b])) begin
        miscompares++;
        $display("FAIL stall_raw_lag%0d: got %0d expected %0d", b, cap0[b], raw[b]);
      end
      if (cap1[b] !== AW'(nrm[b])) begin
        miscompares++;
        $display("FAIL stall_norm_lag%0d: got %0d expected %0d", b, cap1[b], nrm[b]);
      end
      if (cap_lag[b] !== LW'(b)) begin
        miscompares++;
        $display("FAIL stall_out_lag%0d: got %0d expected %0d", b, cap_lag[b], b);
      end
    end
  endtask

  task automatic test_gapped();
    int raw [M];
    int nrm [M];
    raw = '{30, 20};
    nrm = '{7, 5};
    send_frame(1, 2, 3, 4, 1'b1);
    collect_drain();
    for (int b = 0; b < M; b++) begin
      vectors += 2;
      if (cap0[b] !== AW'(raw[b])) begin
        miscompares++;
        $display("FAIL gap_raw_lag%0d: got %0d expected %0d", b, cap0[b], raw[b]);
      end
      if (cap1[b] !== AW'(nrm[b])) begin
        miscompares++;
        $display("FAIL gap_norm_lag%0d: got %0d expected %0d", b, cap1[b], nrm[b]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int raw [M];
    int nrm [M];
    raw = '{16, 12};
    nrm = '{4, 3};
    send_sample(8'sd5);
    send_sample(8'sd5);
    rst = 1'b1;
    step();
    vectors += 2;
    if ({in_ready0, out_valid0, out_data0, out_lag0, out_last0, busy0} !== '0) begin
      miscompares++;
      $display("FAIL midreset_raw: outputs got %h expected 0",
               {in_ready0, out_valid0, out_data0, out_lag0, out_last0, busy0});
    end
    if ({in_ready1, out_valid1, out_data1, out_lag1, out_last1, busy1} !== '0) begin
      miscompares++;
      $display("FAIL midreset_norm: outputs got %h expected 0",
               {in_ready1, out_valid1, out_data1, out_lag1, out_last1, busy1});
    end
    step();
    rst = 1'b0;
    send_frame(2, 2, 2, 2);
    collect_drain();
    for (int b = 0; b < M; b++) begin
      vectors += 2;
      if (cap0[b] !== AW'(raw[b])) begin
        miscompares++;
        $display("FAIL midreset_raw_lag%0d: got %0d expected %0d", b, cap0[b], raw[b]);
      end
      if (cap1[b] !== AW'(nrm[b])) begin
        miscompares++;
        $display("FAIL midreset_norm_lag%0d: got %0d expected %0d", b, cap1[b], nrm[b]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (out_valid0 !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_extra_drain%0d: out_valid got %0b expected 0", c, out_valid0);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_back_to_back_ramp();
    test_alternating();
    test_stall();
    test_gapped();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/autocorr_engine.md
# autocorr_engine

Streaming multi-lag autocorrelator: accepts a stream of signed ADC samples, accumulates r[k] = Σ x[n]·x[n−k] for lags k = 0..M−1 over a frame of N samples, then drains the M results one lag per beat over a valid/ready output. It sits between the ADC sample path (counter and shift-register front end) and downstream normalisation and readout. It is the parametrised successor to the fixed 3-lag MAC chain: it adds input/output handshaking, frame sequencing and optional built-in biased normalisation.

## Interface
- DW, 16: signed input sample width.
- N, 64: frame length in samples; power of 2, N ≥ M.
- M, 8: number of lags; M ≥ 1.
- NORM, 1: 0 = raw sums out; 1 = sums arithmetic-shifted right by log2(N).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DW  signed sample.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  ACC_W  signed r[out_lag]; ACC_W = 2·DW + log2(N).
- out_lag  out  max(1,$clog2(M))  lag index of the current beat.
- out_last  out  1  high on the beat with out_lag = M−1.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, ACCUM and DRAIN. Reset enters IDLE; the next cycle moves IDLE→ACCUM unconditionally. IDLE exists only to clear storage.
- A sample is accepted when in_valid && in_ready. in_ready = (state == ACCUM).
- Delay line d[0..M−1] holds x[n], x[n−1], …; it is zeroed at frame start. Terms with n < k therefore contribute 0, giving exactly N−k products per lag.
- On each accepted sample: acc[k] += in_data · d[k−1] for k ≥ 1, acc[0] += in_data², then the delay line shifts. Products are full 2·DW signed. Accumulators are ACC_W signed and cannot overflow.
- A sample counter runs 0..N−1. Acceptance at count N−1 moves the state to DRAIN and resets the count to 0.
- In DRAIN, out_valid = 1 and out_data = acc[idx] (NORM=1: arithmetic >>> log2(N), which floors). idx starts at 0 and advances on each out_valid && out_ready.
- A handshake with idx = M−1 clears all acc, the delay line and idx, and moves the state to ACCUM.
- Gaps in in_valid pause accumulation with no effect on the result.
- Reset mid-frame or mid-drain discards all partial state. No out_valid is produced for an aborted frame.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_lag=0, out_last=0, busy=0. The first in_ready is the second cycle after rst deasserts.
- Accumulate latency: the acc registers reflect a sample on the edge at which it is accepted.
- The first out_valid appears the cycle after the last sample is accepted (1-cycle latency).
- Drain takes M cycles minimum at out_ready=1. Throughput is N input cycles plus M drain cycles per frame.
- While out_valid && !out_ready, out_data, out_lag and out_last are held stable.
- in_ready is 0 throughout DRAIN. The first in_ready after a drain is the cycle after the last beat's handshake.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package autocorr_pkg holds:
  - the state enum typedef;
  - a function acc_w(DW, N);
  - a function lag_w(M).
- Sub-module lag_mac holds one lag's multiply-accumulate with clear and enable. It is generated M times.
- The top level holds the FSM, the delay line, the counters, the output mux and the normaliser.

## Test plan
All scenarios use DW=8, N=4, M=2 unless stated otherwise.
- Constant 2,2,2,2 with NORM=0 → beats (lag0=16), (lag1=12, out_last=1). With NORM=1 → 4, 3.
- Ramp 1,2,3,4 with NORM=1 → r0 = 30>>>2 = 7, r1 = 20>>>2 = 5. Repeating the ramp in the next frame gives identical results, confirming the clear between frames.
- Alternating −3,3,−3,3 with NORM=1 → r0 = 36>>>2 = 9, r1 = −27>>>2 = −7, checking the floor.
- Hold out_ready=0 for 5 cycles in DRAIN → lag0 is held stable, in_ready stays 0, and no data is lost. Then release → both beats arrive in order.
- Assert in_valid only on alternating cycles with the ramp → same results as the contiguous ramp.
- Assert rst after 2 samples, then send a full constant-2 frame → only one drain occurs, with values 16, 12 (NORM=0). All outputs are at reset values during rst.
